ps2_make_filter: RTL and testbench

Scan-code sequencing stage between the PS/2 byte receiver and the morse data control. Consumes raw PS/2 set-2 bytes with a one-cycle strobe. Strips break (F0) and extended (E0) prefixes, discards keyboard status bytes and suppresses typematic auto-repeat. Emits exactly one make-code event per physical key press.

---
 rtl/ps2_pkg.sv | 28 ++
 rtl/ps2_make_filter.sv | 132 +++++++++++++
 tb/tb_ps2_make_filter.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/ps2_pkg.sv
// Shared PS/2 set-2 scan-code constants, sequencer state type and the
// classifier for keyboard status bytes that never carry a key.
package ps2_pkg;

  localparam logic [7:0] PS2_EXT       = 8'hE0;
  localparam logic [7:0] PS2_BRK       = 8'hF0;
  localparam logic [7:0] PS2_ERR_LO    = 8'h00;
  localparam logic [7:0] PS2_BAT_OK    = 8'hAA;
  localparam logic [7:0] PS2_ECHO      = 8'hEE;
  localparam logic [7:0] PS2_ACK       = 8'hFA;
  localparam logic [7:0] PS2_BAT_FAIL0 = 8'hFC;
  localparam logic [7:0] PS2_BAT_FAIL1 = 8'hFD;
  localparam logic [7:0] PS2_RESEND    = 8'hFE;
  localparam logic [7:0] PS2_ERR_HI    = 8'hFF;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_EXT     = 2'd1,
    ST_BRK     = 2'd2,
    ST_EXT_BRK = 2'd3
  } ps2_state_e;

  function automatic logic is_special(input logic [7:0] b);
    return b inside {PS2_ERR_LO, PS2_BAT_OK, PS2_ECHO, PS2_ACK,
                     PS2_BAT_FAIL0, PS2_BAT_FAIL1, PS2_RESEND, PS2_ERR_HI};
  endfunction

endpackage

// File: rtl/ps2_make_filter.sv
// Turns raw PS/2 set-2 bytes into one make-code event per key press, stripping
// E0/F0 prefixes, status bytes and typematic repeats of the held key.
module ps2_make_filter
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYCLES  = 200000,
  parameter bit SUPPRESS_REPEAT = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] ps2_received_data,
  input  logic       ps2_received_data_strb,
  output logic [7:0] key_code,
  output logic       key_extended,
  output logic       key_strb,
  output logic       seq_error
);

  localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] TERM_CNT = CW'(TIMEOUT_CYCLES - 1);

  ps2_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          held_valid_q, held_valid_d;
  logic          held_ext_q, held_ext_d;
  logic [7:0]    held_code_q, held_code_d;
  logic [7:0]    key_code_q, key_code_d;
  logic          key_ext_q, key_ext_d;
  logic          key_strb_q, key_strb_d;
  logic          seq_error_q, seq_error_d;

  logic make_ev, brk_ev, ev_ext, held_match;

  always_comb begin
    state_d      = state_q;
    cnt_d        = '0;
    held_valid_d = held_valid_q;
    held_ext_d   = held_ext_q;
    held_code_d  = held_code_q;
    key_code_d   = key_code_q;
    key_ext_d    = key_ext_q;
    key_strb_d   = 1'b0;
    seq_error_d  = 1'b0;
    make_ev      = 1'b0;
    brk_ev       = 1'b0;
    ev_ext       = 1'b0;

    // A strobe always takes priority over the timeout, even on terminal count.
    if (ps2_received_data_strb) begin
      if (is_special(ps2_received_data)) begin
        state_d = ST_IDLE;
      end else begin
        unique case (state_q)
          ST_IDLE: begin
            if (ps2_received_data == PS2_EXT)      state_d = ST_EXT;
            else if (ps2_received_data == PS2_BRK) state_d = ST_BRK;
            else                                   make_ev = 1'b1;
          end
          ST_EXT: begin
            if (ps2_received_data == PS2_BRK)      state_d = ST_EXT_BRK;
            else if (ps2_received_data != PS2_EXT) begin
              make_ev = 1'b1;
              ev_ext  = 1'b1;
              state_d = ST_IDLE;
            end
          end
          ST_BRK: begin
            brk_ev  = 1'b1;
            state_d = ST_IDLE;
          end
          ST_EXT_BRK: begin
            brk_ev  = 1'b1;
            ev_ext  = 1'b1;
            state_d = ST_IDLE;
          end
          default: state_d = ST_IDLE;
        endcase
      end
    end else if (state_q != ST_IDLE) begin
      if (cnt_q == TERM_CNT) begin
        state_d     = ST_IDLE;
        seq_error_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end

    held_match = ({held_ext_q, held_code_q} == {ev_ext, ps2_received_data});

    if (make_ev && !(SUPPRESS_REPEAT && held_valid_q && held_match)) begin
      key_code_d   = ps2_received_data;
      key_ext_d    = ev_ext;
      key_strb_d   = 1'b1;
      held_valid_d = 1'b1;
      held_ext_d   = ev_ext;
      held_code_d  = ps2_received_data;
    end

    // Releasing some other key leaves the held key armed for repeat suppression.
    if (brk_ev && held_match) held_valid_d = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      held_valid_q <= 1'b0;
      held_ext_q   <= 1'b0;
      held_code_q  <= 8'h00;
      key_code_q   <= 8'h00;
      key_ext_q    <= 1'b0;
      key_strb_q   <= 1'b0;
      seq_error_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      held_valid_q <= held_valid_d;
      held_ext_q   <= held_ext_d;
      held_code_q  <= held_code_d;
      key_code_q   <= key_code_d;
      key_ext_q    <= key_ext_d;
      key_strb_q   <= key_strb_d;
      seq_error_q  <= seq_error_d;
    end
  end

  assign key_code     = key_code_q;
  assign key_extended = key_ext_q;
  assign key_strb     = key_strb_q;
  assign seq_error    = seq_error_q;

endmodule

// File: tb/tb_ps2_make_filter.sv
// Directed bench for ps2_make_filter: expected make events go into a queue as
// bytes are driven and are popped and compared when key_strb appears.
module tb_ps2_make_filter;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] ps2_received_data;
  logic       ps2_received_data_strb;
  logic [7:0] key_code;
  logic       key_extended;
  logic       key_strb;
  logic       seq_error;

  int checks   = 0;
  int failures = 0;

  logic [8:0] exp_q[$];
  logic [8:0] last_ev = 9'h000;

  ps2_make_filter #(
    .TIMEOUT_CYCLES (16),
    .SUPPRESS_REPEAT(1'b1)
  ) dut (
    .clk                   (clk),
    .rst                   (rst),
    .ps2_received_data     (ps2_received_data),
    .ps2_received_data_strb(ps2_received_data_strb),
    .key_code              (key_code),
    .key_extended          (key_extended),
    .key_strb              (key_strb),
    .seq_error             (seq_error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  // Called #1 after every active edge: checks pulses and the held key outputs.
  task automatic check_out(input bit exp_strb, input bit exp_err);
    chk("key_strb", {31'd0, key_strb}, {31'd0, exp_strb});
    chk("seq_error", {31'd0, seq_error}, {31'd0, exp_err});
    if (exp_strb && exp_q.size() > 0) last_ev = exp_q.pop_front();
    chk("key_code", {24'd0, key_code}, {24'd0, last_ev[7:0]});
    chk("key_extended", {31'd0, key_extended}, {31'd0, last_ev[8]});
  endtask

  task automatic send(input logic [7:0] b, input bit emit, input bit ext);
    @(negedge clk);
    ps2_received_data      = b;
    ps2_received_data_strb = 1'b1;
    if (emit) exp_q.push_back({ext, b});
    @(posedge clk);
    #1;
    ps2_received_data_strb = 1'b0;
    check_out(emit, 1'b0);
  endtask

  task automatic idle(input int n, input int err_at);
    for (int i = 1; i <= n; i++) begin
      @(posedge clk);
      #1;
      check_out(1'b0, i == err_at);
    end
  endtask

  initial begin
    rst                    = 1'b1;
    ps2_received_data      = 8'h00;
    ps2_received_data_strb = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_out(1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    idle(2, 0);

    // Plain press and release.
    send(8'h1C, 1, 0);
    send(8'hF0, 0, 0);
    send(8'h1C, 0, 0);
    idle(2, 0);

    // Typematic repeat suppressed until the key is released.
    send(8'h1C, 1, 0);
    send(8'h1C, 0, 0);
    send(8'h1C, 0, 0);
    send(8'hF0, 0, 0);
    send(8'h1C, 0, 0);
    send(8'h1C, 1, 0);
    send(8'hF0, 0, 0);
    send(8'h1C, 0, 0);

    // Extended key, release, then the same code unprefixed.
    send(8'hE0, 0, 0);
    send(8'h75, 1, 1);
    send(8'hE0, 0, 0);
    send(8'hF0, 0, 0);
    send(8'h75, 0, 0);
    send(8'h75, 1, 0);
    // Same code with E0 is a distinct key; E0 E0 stays in the extended state.
    send(8'hE0, 0, 0);
    send(8'hE0, 0, 0);
    send(8'h75, 1, 1);
    send(8'hF0, 0, 0);
    send(8'h75, 0, 0);
    send(8'hE0, 0, 0);
    send(8'hF0, 0, 0);
    send(8'h75, 0, 0);

    // Abandoned break prefix times out 16 cycles after F0.
    send(8'hF0, 0, 0);
    idle(16, 16);
    idle(1, 0);
    send(8'h1C, 1, 0);
    send(8'hF0, 0, 0);
    send(8'h1C, 0, 0);

    // Strobe on terminal count wins: processed as a break, no seq_error.
    send(8'hF0, 0, 0);
    idle(15, 0);
    send(8'h2A, 0, 0);
    idle(20, 0);

    // Status bytes are dropped in any state.
    send(8'hAA, 0, 0);
    send(8'hFA, 0, 0);
    send(8'hE0, 0, 0);
    send(8'hEE, 0, 0);
    send(8'h1C, 1, 0);
    send(8'hF0, 0, 0);
    send(8'hFF, 0, 0);
    send(8'h1C, 0, 0);

    // Reset mid-sequence with 1C still held: everything clears.
    send(8'hE0, 0, 0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    last_ev = 9'h000;
    check_out(1'b0, 1'b0);
    idle(2, 0);
    @(negedge clk);
    rst = 1'b0;
    send(8'h1C, 1, 0);
    idle(20, 0);

    chk("queue_empty", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
